// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: two-flop synchroniser, optional per-bit glitch
// filter, and registered change strobes for the DATA_IN register and the
// interrupt logic.
//
// Strobe semantics: hw2reg_o.data_in.de is a one-cycle write strobe. It fires
// in the cycle after the filtered word d changes. There is no ready/backpressure,
// so the consumer must accept every strobe. rise_o/fall_o are aligned with de.

package gpio_reg_pkg;

  typedef struct packed {
    logic [31:0] d;
    logic        de;
  } gpio_hw2reg_data_in_reg_t;

  typedef struct packed {
    gpio_hw2reg_data_in_reg_t data_in;
  } gpio_hw2reg_t;

endpackage

module gpio_in_filter #(
  parameter int unsigned FilterCycles = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                gpio_i,
  input  logic [31:0]                filter_en_i,
  output gpio_reg_pkg::gpio_hw2reg_t hw2reg_o,
  output logic [31:0]                rise_o,
  output logic [31:0]                fall_o
);

  // Counter holds 0..FilterCycles-1, with at least one bit for FilterCycles = 1.
  localparam int unsigned     CntW   = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic [31:0]     sync1;
  logic [31:0]     sync2;
  logic [31:0]     d;
  logic [31:0]     d_next;
  logic [31:0]     d_prev;
  logic            de;
  logic [CntW-1:0] cnt      [32];
  logic [CntW-1:0] cnt_next [32];

  // Per-bit filter decision: disabled bits follow sync2 directly; enabled bits
  // change only after sync2 has disagreed with d for FilterCycles edges in a row.
  always_comb begin
    d_next = d;
    for (int i = 0; i < 32; i++) begin
      cnt_next[i] = cnt[i];
      if (!filter_en_i[i]) begin
        d_next[i]   = sync2[i];
        cnt_next[i] = '0;
      end else if (sync2[i] == d[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CntMax) begin
        d_next[i]   = sync2[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CntW'(1);
      end
    end
  end

  // Synchroniser, filter state, and change strobes derived from d vs its
  // previous value (so strobes trail the d update by one edge).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= '0;
      sync2  <= '0;
      d      <= '0;
      d_prev <= '0;
      de     <= 1'b0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= gpio_i;
      sync2  <= sync1;
      d      <= d_next;
      d_prev <= d;
      de     <= |(d ^ d_prev);
      rise_o <= d & ~d_prev;
      fall_o <= ~d & d_prev;
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign hw2reg_o.data_in.d  = d;
  assign hw2reg_o.data_in.de = de;

endmodule
